regfile_2r1w: RTL and testbench

Dual-read, single-write 32 x 64-bit register file for the MIPS datapath. It is the read side of the storage built from the team's 5-bit address and 64-bit data registers. The write port updates one entry per cycle. Each of two read ports returns a registered 64-bit operand one cycle after its request, with a valid strobe and same-cycle write bypass. It sits between instruction decode (register addresses) and the gate-level ALU (operand inputs).

---
 rtl/regfile_2r1w.sv | 74 +++++++
 tb/tb_regfile_2r1w.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w.sv
// 32 x 64-bit register file: one write port, two registered read ports with
// valid strobes and same-edge write bypass. Entry 0 always reads as zero.
module regfile_2r1w #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic              RdEnA,
    input  logic [ADDR_W-1:0] RdAddrA,
    output logic [DATA_W-1:0] RdDataA,
    output logic              RdValidA,
    input  logic              RdEnB,
    input  logic [ADDR_W-1:0] RdAddrB,
    output logic [DATA_W-1:0] RdDataB,
    output logic              RdValidB
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] next_a;
    logic [DATA_W-1:0] next_b;

    // Resolve one read: address 0 is constant zero, a same-edge write wins over storage.
    function automatic logic [DATA_W-1:0] read_word(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              wr_en,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [DATA_W-1:0] wr_data
    );
        logic [DATA_W-1:0] word;
        word = '0;
        if (addr != '0) begin
            if (wr_en && (wr_addr == addr)) word = wr_data;
            else                            word = stored;
        end
        return word;
    endfunction

    always_comb begin
        next_a = read_word(RdAddrA, mem[RdAddrA], WrEn, WrAddr, WrData);
        next_b = read_word(RdAddrB, mem[RdAddrB], WrEn, WrAddr, WrData);
    end

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (WrEn && (WrAddr != '0)) begin
            mem[WrAddr] <= WrData;
        end
    end

    // Read data holds between requests; only the valid strobe drops when idle.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            RdDataA  <= '0;
            RdValidA <= 1'b0;
            RdDataB  <= '0;
            RdValidB <= 1'b0;
        end else begin
            RdValidA <= RdEnA;
            RdValidB <= RdEnB;
            if (RdEnA) RdDataA <= next_a;
            if (RdEnB) RdDataB <= next_b;
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: array-based reference model updated per clock edge,
// a negedge compare process, directed scenarios plus randomized traffic.
module tb_regfile_2r1w;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        WrEn = 1'b0;
    logic [4:0]  WrAddr = '0;
    logic [63:0] WrData = '0;
    logic        RdEnA = 1'b0;
    logic [4:0]  RdAddrA = '0;
    logic [63:0] RdDataA;
    logic        RdValidA;
    logic        RdEnB = 1'b0;
    logic [4:0]  RdAddrB = '0;
    logic [63:0] RdDataB;
    logic        RdValidB;

    regfile_2r1w #(.ADDR_W(5), .DATA_W(64)) dut (
        .CLK(CLK), .Reset(Reset),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdDataA(RdDataA), .RdValidA(RdValidA),
        .RdEnB(RdEnB), .RdAddrB(RdAddrB), .RdDataB(RdDataB), .RdValidB(RdValidB)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    bit done = 1'b0;

    logic [63:0] model [32];
    logic [63:0] exp_a = '0, exp_b = '0;
    logic        exp_va = 1'b0, exp_vb = 1'b0;

    localparam logic [63:0] STRIDE = 64'h0101_0101_0101_0101;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [63:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 64'd0;
        if (WrEn && WrAddr == a) return WrData;
        return model[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = '0;
        exp_a = '0; exp_b = '0; exp_va = 1'b0; exp_vb = 1'b0;
    endtask

    // One clock: model follows the edge using the inputs the DUT sampled, then wait to the negedge.
    task automatic step();
        @(posedge CLK);
        if (!Reset) begin
            exp_va = RdEnA;
            exp_vb = RdEnB;
            if (RdEnA) exp_a = model_read(RdAddrA);
            if (RdEnB) exp_b = model_read(RdAddrB);
            if (WrEn && WrAddr != 5'd0) model[WrAddr] = WrData;
        end
        @(negedge CLK);
    endtask

    task automatic set_wr(input logic en, input logic [4:0] a, input logic [63:0] d);
        WrEn = en; WrAddr = a; WrData = d;
    endtask

    task automatic set_rd(input logic ea, input logic [4:0] aa, input logic eb, input logic [4:0] ab);
        RdEnA = ea; RdAddrA = aa; RdEnB = eb; RdAddrB = ab;
    endtask

    always @(negedge CLK) begin
        if (!done) begin
            chk("cyc_valid_a", {63'd0, RdValidA}, {63'd0, exp_va});
            chk("cyc_valid_b", {63'd0, RdValidB}, {63'd0, exp_vb});
            chk("cyc_data_a", RdDataA, exp_a);
            chk("cyc_data_b", RdDataB, exp_b);
        end
    end

    initial begin
        logic [4:0] addrs [3];
        addrs[0] = 5'd0; addrs[1] = 5'd5; addrs[2] = 5'd31;
        model_reset();

        repeat (2) @(negedge CLK);
        chk("reset_valid_a", {63'd0, RdValidA}, 64'd0);
        chk("reset_data_b", RdDataB, 64'd0);
        Reset = 1'b0;

        // Reads of zeroed storage, each followed by an idle cycle.
        for (int i = 0; i < 3; i++) begin
            set_rd(1'b1, addrs[i], 1'b1, addrs[i]);
            step();
            chk("init_rd_a", RdDataA, 64'd0);
            chk("init_rd_vb", {63'd0, RdValidB}, 64'd1);
            set_rd(1'b0, 5'd0, 1'b0, 5'd0);
            step();
            chk("init_idle_va", {63'd0, RdValidA}, 64'd0);
        end

        set_wr(1'b1, 5'd7, 64'h0123_4567_89AB_CDEF);
        step();
        set_wr(1'b0, 5'd0, 64'd0);
        set_rd(1'b1, 5'd7, 1'b1, 5'd6);
        step();
        chk("w7_model_a", exp_a, 64'h0123_4567_89AB_CDEF);
        chk("w7_rd_a", RdDataA, 64'h0123_4567_89AB_CDEF);
        chk("w6_rd_b", RdDataB, 64'd0);

        set_rd(1'b0, 5'd0, 1'b0, 5'd0);
        set_wr(1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        set_wr(1'b0, 5'd0, 64'd0);
        set_rd(1'b1, 5'd0, 1'b1, 5'd0);
        step();
        chk("zero_rd_a", RdDataA, 64'd0);
        chk("zero_rd_b", RdDataB, 64'd0);

        // Same-edge write and read of address 12 returns the new value.
        set_rd(1'b0, 5'd0, 1'b0, 5'd0);
        set_wr(1'b1, 5'd12, 64'h11);
        step();
        set_wr(1'b1, 5'd12, 64'h22);
        set_rd(1'b1, 5'd12, 1'b1, 5'd12);
        step();
        chk("byp_model", exp_b, 64'h22);
        chk("byp_a", RdDataA, 64'h22);
        chk("byp_b", RdDataB, 64'h22);
        set_wr(1'b0, 5'd0, 64'd0);
        set_rd(1'b1, 5'd12, 1'b0, 5'd0);
        step();
        chk("byp_after_a", RdDataA, 64'h22);

        set_rd(1'b0, 5'd0, 1'b0, 5'd0);
        for (int i = 1; i < 32; i++) begin
            set_wr(1'b1, 5'(i), 64'(i) * STRIDE);
            step();
        end
        set_wr(1'b0, 5'd0, 64'd0);
        for (int i = 1; i < 32; i++) begin
            set_rd(1'b1, 5'(i), 1'b1, 5'(32 - i));
            step();
            chk("stream_a", RdDataA, 64'(i) * STRIDE);
            chk("stream_b", RdDataB, 64'(32 - i) * STRIDE);
            chk("stream_va", {63'd0, RdValidA}, 64'd1);
        end
        set_rd(1'b0, 5'd0, 1'b0, 5'd0);
        step();
        chk("hold_a", RdDataA, 64'h1F1F_1F1F_1F1F_1F1F);
        chk("hold_b", RdDataB, 64'h0101_0101_0101_0101);
        chk("hold_vb", {63'd0, RdValidB}, 64'd0);

        for (int n = 0; n < 400; n++) begin
            set_wr($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
                   {$urandom, $urandom});
            set_rd($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
                   $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 7) == 0) RdAddrB = RdAddrA;
            if ($urandom_range(0, 5) == 0) RdAddrA = WrAddr;
            step();
        end

        // Asynchronous reset in the middle of streaming reads and a write to 9.
        set_wr(1'b1, 5'd9, 64'hDEAD_BEEF_CAFE_F00D);
        set_rd(1'b1, 5'd9, 1'b1, 5'd3);
        step();
        set_wr(1'b1, 5'd9, 64'h1234_5678_9ABC_DEF0);
        set_rd(1'b1, 5'd4, 1'b1, 5'd9);
        #2;
        Reset = 1'b1;
        model_reset();
        #1;
        chk("async_data_a", RdDataA, 64'd0);
        chk("async_data_b", RdDataB, 64'd0);
        chk("async_valid_a", {63'd0, RdValidA}, 64'd0);
        chk("async_valid_b", {63'd0, RdValidB}, 64'd0);
        step();
        Reset = 1'b0;
        set_wr(1'b0, 5'd0, 64'd0);
        set_rd(1'b1, 5'd9, 1'b1, 5'd9);
        step();
        chk("post_rst_9a", RdDataA, 64'd0);
        chk("post_rst_9b", RdDataB, 64'd0);
        for (int i = 0; i < 32; i++) begin
            set_rd(1'b1, 5'(i), 1'b1, 5'(31 - i));
            step();
            chk("post_rst_all", RdDataA, 64'd0);
        end
        set_rd(1'b0, 5'd0, 1'b0, 5'd0);
        step();

        #1;
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
